// File: rtl/game_pkg.sv
// Shared game constants: barrel/game state codes, sprite sizes and the
// slot-manager FSM state type.
package game_pkg;

  typedef enum logic [1:0] {
    BARREL_INITIAL = 2'b00,
    BARREL_ROLLING = 2'b01,
    BARREL_FALLING = 2'b10
  } barrel_state_t;

  typedef enum logic [1:0] {
    GAME_START = 2'b00,
    GAME_PLAY  = 2'b01,
    GAME_OVER  = 2'b10
  } game_state_t;

  localparam int MARIO_W_PX = 34;
  localparam int MARIO_H_PX = 36;
  localparam int ROLL_W     = 32;
  localparam int FALL_W     = 42;
  localparam int BARREL_H   = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALLOC,
    ST_SCAN,
    ST_COMMIT
  } mgr_state_t;

endpackage

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD up-counter; holds once every digit reads 9.
module bcd_counter #(
  parameter int DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  output logic [4*DIGITS-1:0] value
);

  logic [4*DIGITS-1:0] next_value;
  logic                carry;
  logic                all_nines;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_value = value;
    carry      = 1'b1;
    all_nines  = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (value[4*d +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (value[4*d +: 4] == 4'd9) begin
          next_value[4*d +: 4] = 4'd0;
        end else begin
          next_value[4*d +: 4] = value[4*d +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value <= '0;
    else if (inc && !all_nines) value <= next_value;
  end

endmodule

// File: rtl/barrel_manager.sv
// Barrel slot manager: allocates slots on Kong drops, scans live slots once per
// frame for collision, jump-over scoring and retirement.
module barrel_manager
  import game_pkg::*;
#(
  parameter int SLOTS      = 16,
  parameter int IW         = $clog2(SLOTS),
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int HIT_FRAMES = 4,
  parameter int DIGITS     = 6,
  parameter int RETIRE_X   = 560,
  parameter int RETIRE_Y   = 410,
  parameter int MARIO_W    = MARIO_W_PX,
  parameter int MARIO_H    = MARIO_H_PX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 frame_tick,
  input  logic                 spawn_req,
  output logic                 spawn_ack,
  output logic                 spawn_miss,
  output logic [IW-1:0]        spawn_slot,
  output logic [SLOTS-1:0]     slot_start,
  output logic [SLOTS-1:0]     slot_kill,
  output logic [SLOTS-1:0]     slot_busy,
  input  logic [SLOTS*X_W-1:0] barrel_x,
  input  logic [SLOTS*Y_W-1:0] barrel_y,
  input  logic [SLOTS*2-1:0]   barrel_state,
  input  logic [X_W-1:0]       mario_x,
  input  logic [Y_W-1:0]       mario_y,
  input  logic                 mario_jumping,
  output logic                 hit,
  output logic [4*DIGITS-1:0]  score_bcd,
  output logic                 frame_overrun
);

  mgr_state_t       state;
  logic [IW-1:0]    idx;
  logic             spawn_pend;
  logic             frame_req;
  logic             any_hit;
  logic [SLOTS-1:0] scored;
  logic [7:0]       hit_cnt;
  logic [7:0]       hit_next;

  logic [X_W-1:0] bx;
  logic [Y_W-1:0] by;
  logic [1:0]     bst;
  logic [X_W:0]   bx_end, mx_end;
  logic [Y_W:0]   by_end, my_end;
  logic           active, x_ovl, y_ovl, overlap, award, retire;

  logic           free_found;
  logic [IW-1:0]  free_idx;

  // Slot under scan; sums carry one extra bit so edge boxes never wrap.
  always_comb begin
    bx      = barrel_x[idx*X_W +: X_W];
    by      = barrel_y[idx*Y_W +: Y_W];
    bst     = barrel_state[idx*2 +: 2];
    bx_end  = {1'b0, bx} + ((bst == BARREL_FALLING) ? (X_W+1)'(FALL_W) : (X_W+1)'(ROLL_W));
    mx_end  = {1'b0, mario_x} + (X_W+1)'(MARIO_W);
    by_end  = {1'b0, by} + (Y_W+1)'(BARREL_H);
    my_end  = {1'b0, mario_y} + (Y_W+1)'(MARIO_H);
    active  = (state == ST_SCAN) && slot_busy[idx] &&
              ((bst == BARREL_ROLLING) || (bst == BARREL_FALLING));
    x_ovl   = ({1'b0, bx} < mx_end) && ({1'b0, mario_x} < bx_end);
    y_ovl   = ({1'b0, by} < my_end) && ({1'b0, mario_y} < by_end);
    overlap = active && x_ovl && y_ovl;
    award   = active && mario_jumping && !scored[idx] && x_ovl && ({1'b0, by} >= my_end);
    retire  = active && (bx > X_W'(RETIRE_X)) && (by > Y_W'(RETIRE_Y));
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    if (!any_hit) hit_next = 8'd0;
    else if (hit_cnt == 8'(HIT_FRAMES)) hit_next = hit_cnt;
    else hit_next = hit_cnt + 8'd1;
  end

  // Allocation results are registered on the IDLE->ALLOC edge, so they are
  // visible during the ALLOC cycle itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      spawn_pend    <= 1'b0;
      frame_req     <= 1'b0;
      any_hit       <= 1'b0;
      scored        <= '0;
      hit_cnt       <= 8'd0;
      hit           <= 1'b0;
      spawn_ack     <= 1'b0;
      spawn_miss    <= 1'b0;
      spawn_slot    <= '0;
      slot_start    <= '0;
      slot_kill     <= '0;
      slot_busy     <= '0;
      frame_overrun <= 1'b0;
    end else begin
      spawn_ack     <= 1'b0;
      spawn_miss    <= 1'b0;
      slot_start    <= '0;
      slot_kill     <= '0;
      frame_overrun <= 1'b0;

      // NOTE: non-blocking assignments resolve last-wins, so the clears inside
      // the case below override these sets when both happen in one cycle.
      if (run && spawn_req) spawn_pend <= 1'b1;
      if (run && frame_tick) begin
        if (state == ST_SCAN || state == ST_COMMIT) frame_overrun <= 1'b1;
        else frame_req <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (spawn_pend) begin
            state      <= ST_ALLOC;
            spawn_pend <= 1'b0;
            if (free_found) begin
              slot_busy[free_idx]  <= 1'b1;
              slot_start[free_idx] <= 1'b1;
              scored[free_idx]     <= 1'b0;
              spawn_slot           <= free_idx;
              spawn_ack            <= 1'b1;
            end else begin
              spawn_miss <= 1'b1;
            end
          end else if (frame_req) begin
            state     <= ST_SCAN;
            idx       <= '0;
            frame_req <= 1'b0;
          end
        end
        ST_ALLOC: state <= ST_IDLE;
        ST_SCAN: begin
          if (overlap) any_hit <= 1'b1;
          if (award) scored[idx] <= 1'b1;
          if (retire) begin
            slot_kill[idx] <= 1'b1;
            slot_busy[idx] <= 1'b0;
          end
          if (idx == IW'(SLOTS - 1)) state <= ST_COMMIT;
          else idx <= idx + 1'b1;
        end
        ST_COMMIT: begin
          hit_cnt <= hit_next;
          any_hit <= 1'b0;
          if (hit_next == 8'(HIT_FRAMES)) hit <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bcd_counter #(.DIGITS(DIGITS)) u_score (
    .clk   (clk),
    .rst   (rst),
    .inc   (award),
    .value (score_bcd)
  );

endmodule

// File: tb/tb_barrel_manager.sv
// Directed self-checking bench for barrel_manager plus a small saturating
// BCD counter instance for the all-nines hold.
module tb_barrel_manager;
  localparam int SLOTS = 16;
  localparam int IW    = 4;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 run = 1'b1;
  logic                 frame_tick = 1'b0;
  logic                 spawn_req = 1'b0;
  logic                 spawn_ack, spawn_miss, hit, frame_overrun;
  logic [IW-1:0]        spawn_slot;
  logic [SLOTS-1:0]     slot_start, slot_kill, slot_busy;
  logic [SLOTS*X_W-1:0] barrel_x;
  logic [SLOTS*Y_W-1:0] barrel_y;
  logic [SLOTS*2-1:0]   barrel_state;
  logic [X_W-1:0]       mario_x = '0;
  logic [Y_W-1:0]       mario_y = '0;
  logic                 mario_jumping = 1'b0;
  logic [23:0]          score_bcd;
  logic                 bcd_inc = 1'b0;
  logic [7:0]           bcd_value;

  logic [X_W-1:0] bx_a [SLOTS];
  logic [Y_W-1:0] by_a [SLOTS];
  logic [1:0]     bs_a [SLOTS];

  int checks = 0;
  int errors = 0;
  logic [SLOTS-1:0] cap_start, kill_or;
  logic             cap_ack, cap_miss;
  logic [IW-1:0]    cap_slot;

  for (genvar g = 0; g < SLOTS; g++) begin : g_pack
    assign barrel_x[g*X_W +: X_W] = bx_a[g];
    assign barrel_y[g*Y_W +: Y_W] = by_a[g];
    assign barrel_state[g*2 +: 2] = bs_a[g];
  end

  always #5 clk = ~clk;

  barrel_manager dut (
    .clk(clk), .rst(rst), .run(run), .frame_tick(frame_tick), .spawn_req(spawn_req),
    .spawn_ack(spawn_ack), .spawn_miss(spawn_miss), .spawn_slot(spawn_slot),
    .slot_start(slot_start), .slot_kill(slot_kill), .slot_busy(slot_busy),
    .barrel_x(barrel_x), .barrel_y(barrel_y), .barrel_state(barrel_state),
    .mario_x(mario_x), .mario_y(mario_y), .mario_jumping(mario_jumping),
    .hit(hit), .score_bcd(score_bcd), .frame_overrun(frame_overrun)
  );

  bcd_counter #(.DIGITS(2)) u_bcd (.clk(clk), .rst(rst), .inc(bcd_inc), .value(bcd_value));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      bx_a[i] = '0; by_a[i] = '0; bs_a[i] = 2'b00;
    end
  endtask

  // Request at cycle t; allocation results are captured at t+2.
  task automatic spawn();
    spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
    step();
    cap_start = slot_start; cap_ack = spawn_ack; cap_miss = spawn_miss; cap_slot = spawn_slot;
    step();
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    kill_or = '0;
    repeat (SLOTS + 2) begin
      step();
      kill_or |= slot_kill;
    end
  endtask

  task automatic set_barrel(input int s, input int x, input int y, input logic [1:0] st);
    bx_a[s] = X_W'(x); by_a[s] = Y_W'(y); bs_a[s] = st;
  endtask

  task automatic hit_case(input string tag, input int x, input logic [1:0] st, input logic exp);
    apply_reset();
    spawn();
    mario_x = 10'd100; mario_y = 9'd200; mario_jumping = 1'b0;
    set_barrel(0, x, 200, st);
    repeat (4) frame();
    check(tag, {31'd0, hit}, {31'd0, exp});
  endtask

  initial begin
    for (int i = 0; i < SLOTS; i++) begin
      bx_a[i] = '0; by_a[i] = '0; bs_a[i] = 2'b00;
    end
    step(2);
    check("reset_busy", {16'd0, slot_busy}, 32'h0);
    check("reset_score", {8'd0, score_bcd}, 32'h0);
    check("reset_hit", {31'd0, hit}, 32'h0);
    check("reset_pulses", {29'd0, spawn_ack, spawn_miss, frame_overrun}, 32'h0);
    rst = 1'b0;

    // Three drops 10 cycles apart take slots 0, 1, 2.
    for (int i = 0; i < 3; i++) begin
      spawn();
      check($sformatf("start_%0d", i), {16'd0, cap_start}, 32'h1 << i);
      check($sformatf("ack_%0d", i), {31'd0, cap_ack}, 32'h1);
      check($sformatf("slot_%0d", i), {28'd0, cap_slot}, i);
      step(7);
    end
    check("busy_three", {16'd0, slot_busy}, 32'h0007);

    for (int i = 3; i < SLOTS; i++) spawn();
    check("busy_full", {16'd0, slot_busy}, 32'hFFFF);
    spawn();
    check("miss_pulse", {31'd0, cap_miss}, 32'h1);
    check("miss_no_ack", {16'd0, cap_start, 15'd0, cap_ack}, 32'h0);
    check("busy_after_miss", {16'd0, slot_busy}, 32'hFFFF);

    // Retire slot 5 from the bottom-right corner, then reuse it.
    mario_x = 10'd300; mario_y = 9'd100;
    set_barrel(5, 600, 420, 2'b01);
    frame();
    check("kill_slot5", {16'd0, kill_or}, 32'h0020);
    check("busy_after_kill", {16'd0, slot_busy}, 32'hFFDF);
    bs_a[5] = 2'b00;
    spawn();
    check("respawn_slot5", {16'd0, cap_start}, 32'h0020);
    check("respawn_idx", {28'd0, cap_slot}, 32'd5);

    // Four colliding frames: hit rises exactly at t+19 of the 4th tick.
    apply_reset();
    spawn();
    mario_x = 10'd110; mario_y = 9'd190;
    set_barrel(0, 100, 200, 2'b01);
    repeat (3) frame();
    check("hit_after_3", {31'd0, hit}, 32'h0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step(17);
    check("hit_t18", {31'd0, hit}, 32'h0);
    step();
    check("hit_t19", {31'd0, hit}, 32'h1);
    mario_x = 10'd400;
    frame();
    check("hit_sticky", {31'd0, hit}, 32'h1);

    // Debounce: a clear frame resets the run of hit frames.
    apply_reset();
    spawn();
    set_barrel(0, 100, 200, 2'b01);
    mario_x = 10'd110; mario_y = 9'd190;
    repeat (3) frame();
    mario_x = 10'd400;
    frame();
    mario_x = 10'd110;
    repeat (3) frame();
    check("debounce_3_1_3", {31'd0, hit}, 32'h0);

    hit_case("edge_mx_plus_34", 134, 2'b01, 1'b0);
    hit_case("edge_mx_plus_33", 133, 2'b01, 1'b1);
    hit_case("roll_left_59", 59, 2'b01, 1'b0);
    hit_case("fall_left_59", 59, 2'b10, 1'b1);

    // Jump-over scoring: one award per barrel regardless of frame count.
    apply_reset();
    spawn();
    mario_x = 10'd100; mario_y = 9'd150; mario_jumping = 1'b1;
    set_barrel(0, 105, 190, 2'b01);
    frame();
    check("score_first", {8'd0, score_bcd}, 32'h000001);
    repeat (4) frame();
    check("score_once", {8'd0, score_bcd}, 32'h000001);
    check("jump_no_hit", {31'd0, hit}, 32'h0);
    spawn();
    set_barrel(1, 105, 190, 2'b01);
    frame();
    check("score_second", {8'd0, score_bcd}, 32'h000002);

    // Saturating BCD counter (2 digits): carry and all-nines hold.
    bcd_inc = 1'b1;
    step(10);
    bcd_inc = 1'b0;
    check("bcd_carry_10", {24'd0, bcd_value}, 32'h10);
    bcd_inc = 1'b1;
    step(95);
    bcd_inc = 1'b0;
    check("bcd_saturate_99", {24'd0, bcd_value}, 32'h99);

    // Overrun: second tick two cycles after the first lands inside SCAN.
    mario_jumping = 1'b0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("overrun_pulse", {31'd0, frame_overrun}, 32'h1);
    step();
    check("overrun_one_cycle", {31'd0, frame_overrun}, 32'h0);

    // Reset mid-scan clears everything at once.
    rst = 1'b1;
    #1;
    check("midscan_rst_busy", {16'd0, slot_busy}, 32'h0);
    check("midscan_rst_score", {8'd0, score_bcd}, 32'h0);
    step();
    rst = 1'b0;
    step(20);
    check("no_pulse_after_rst", {15'd0, slot_kill, frame_overrun}, 32'h0);

    // The next scan starts at slot 0: its retire pulse shows at t+3.
    spawn();
    mario_x = 10'd300; mario_y = 9'd100;
    set_barrel(0, 600, 420, 2'b01);
    set_barrel(1, 0, 0, 2'b00);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    check("scan0_t2", {16'd0, slot_kill}, 32'h0);
    step();
    check("scan0_t3_kill", {16'd0, slot_kill}, 32'h0001);
    step(17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
